mem_dump_reader: RTL and testbench

//  Read-side counterpart of the external program/data load port (ewr/ead/edat) of the 8-bit RISC CPU.

---
 rtl/mem_dump_reader.sv | 162 ++++++++++++++++
 tb/tb_mem_dump_reader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_reader.sv
// mem_dump_reader
//   Streams a contiguous window of the unified 32x8 memory out as (addr,data)
//   beats on a valid/ready interface. It sits on the memory's external side
//   next to the load port and only reads. Typical use: dump results after HLT.
//
//   Optional feature macro: MEM_DUMP_CHECKSUM_EN
//     Appends one extra beat (addr 0, mod-2^DW sum of the dumped bytes) after
//     the last data beat. In that build out_last_o marks the checksum beat.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 dump request, only looked at while idle
//   first_addr_i/last_addr_i  inclusive window, wraps past the top address
//   busy_o                  dump in progress (cycle after start .. done)
//   done_o                  one-cycle pulse after the final beat is accepted
//   rd_en_o/rd_addr_o       memory read strobe/address
//   rd_data_i               read data, valid one cycle after rd_en_o
//   out_valid_o/out_ready_i beat handshake
//   out_addr_o/out_data_o   beat payload
//   out_last_o              final beat of the dump
module mem_dump_reader #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [AW-1:0] first_addr_i,
  input  logic [AW-1:0] last_addr_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [DW-1:0] rd_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [AW-1:0] out_addr_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WT   = 3'd2,
    S_SEND = 3'd3,
`ifdef MEM_DUMP_CHECKSUM_EN
    S_CSUM = 3'd5,
`endif
    S_FIN  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cur_q, cur_d;
  // One bit wider than the address so a full 2^AW-word window fits.
  logic [AW:0]   rem_q, rem_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] span;
  logic          last_word;

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DW-1:0] sum_q, sum_d;
`endif

  // Modular distance, so last < first wraps through the top address.
  assign span      = last_addr_i - first_addr_i;
  assign last_word = (rem_q == (AW+1)'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      rem_q      <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      rem_q      <= rem_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
`ifdef MEM_DUMP_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    rem_d      = rem_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
`ifdef MEM_DUMP_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cur_d   = first_addr_i;
          rem_d   = {1'b0, span} + (AW+1)'(1);
`ifdef MEM_DUMP_CHECKSUM_EN
          sum_d   = '0;
`endif
          state_d = S_RD;
        end
      end
      S_RD: state_d = S_WT;
      S_WT: begin
        // Memory answers one cycle after the strobe; latch it as the beat.
        out_addr_d = cur_q;
        out_data_d = rd_data_i;
`ifdef MEM_DUMP_CHECKSUM_EN
        sum_d      = sum_q + rd_data_i;
`endif
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (out_ready_i) begin
          cur_d = cur_q + AW'(1);
          rem_d = rem_q - (AW+1)'(1);
          if (last_word) begin
`ifdef MEM_DUMP_CHECKSUM_EN
            out_addr_d = '0;
            out_data_d = sum_q;
            state_d    = S_CSUM;
`else
            state_d    = S_FIN;
`endif
          end else begin
            state_d = S_RD;
          end
        end
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      S_CSUM: if (out_ready_i) state_d = S_FIN;
`endif
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_FIN);
  assign rd_en_o    = (state_q == S_RD);
  assign rd_addr_o  = (state_q == S_RD) ? cur_q : '0;
  assign out_addr_o = out_addr_q;
  assign out_data_o = out_data_q;

`ifdef MEM_DUMP_CHECKSUM_EN
  assign out_valid_o = (state_q == S_SEND) || (state_q == S_CSUM);
  assign out_last_o  = (state_q == S_CSUM);
`else
  assign out_valid_o = (state_q == S_SEND);
  assign out_last_o  = (state_q == S_SEND) && last_word;
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
module tb_mem_dump_reader;

  logic       clk = 1'b0;
  logic       rst, start, out_ready;
  logic [4:0] first_addr, last_addr;
  logic       busy, done, rd_en, out_valid, out_last;
  logic [4:0] rd_addr, out_addr;
  logic [7:0] rd_data, out_data;

  always #5 clk = ~clk;

  mem_dump_reader #(.AW(5), .DW(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .first_addr_i(first_addr), .last_addr_i(last_addr),
    .busy_o(busy), .done_o(done), .rd_en_o(rd_en), .rd_addr_o(rd_addr),
    .rd_data_i(rd_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_addr_o(out_addr), .out_data_o(out_data), .out_last_o(out_last)
  );

  // Synchronous-read memory model: data one cycle after the strobe.
  logic [7:0] mem [32];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
    logic       l;
  } beat_t;
  beat_t sb[$];

  int tests = 0, fails = 0;
  int rd_cnt = 0, done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: beat scoreboard, hold-stability, strobe/done counting.
  logic       hold = 1'b0;
  logic [4:0] h_a;
  logic [7:0] h_d;
  logic       h_l;
  always @(negedge clk) begin
    if (rd_en) rd_cnt++;
    if (done) done_cnt++;
    if (out_valid) chk("no_read_while_beat", {31'd0, rd_en}, 32'd0);
    if (hold && !rst) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_payload", {18'd0, out_addr, out_data, out_last}, {18'd0, h_a, h_d, h_l});
    end
    if (out_valid && out_ready && !rst) begin
      if (sb.size() == 0) chk("unexpected_beat", {18'd0, out_addr, out_data, out_last}, 32'hFFFF_FFFF);
      else begin
        beat_t e;
        e = sb.pop_front();
        chk("beat", {18'd0, out_addr, out_data, out_last}, {18'd0, e.a, e.d, e.l});
      end
    end
    hold = out_valid && !out_ready && !rst;
    h_a = out_addr; h_d = out_data; h_l = out_last;
  end

  function automatic int nwords(input logic [4:0] f, input logic [4:0] l);
    logic [4:0] s;
    s = l - f;
    return int'(s) + 1;
  endfunction

  task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
    int n;
    logic [4:0] a;
    logic [7:0] sum;
    n = nwords(f, l);
    sum = 8'd0;
    a = f;
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.a = a; b.d = mem[a];
`ifdef MEM_DUMP_CHECKSUM_EN
      b.l = 1'b0;
`else
      b.l = (i == n - 1);
`endif
      sum = sum + mem[a];
      sb.push_back(b);
      a = a + 5'd1;
    end
`ifdef MEM_DUMP_CHECKSUM_EN
    begin
      beat_t c;
      c.a = 5'd0; c.d = sum; c.l = 1'b1;
      sb.push_back(c);
    end
`endif
    rd_cnt = 0; done_cnt = 0;
    @(negedge clk);
    start = 1'b1; first_addr = f; last_addr = l;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int n, input bit chk_lat);
    int cyc, exp_cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 3000);
    chk("done_seen", {31'd0, done}, 32'd1);
`ifdef MEM_DUMP_CHECKSUM_EN
    exp_cyc = 3 * n + 2;
`else
    exp_cyc = 3 * n + 1;
`endif
    if (chk_lat) chk("latency", cyc, exp_cyc);
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("done_one_pulse", done_cnt, 32'd1);
    chk("rd_en_pulses", rd_cnt, n);
    chk("sb_empty", sb.size(), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 13 + 7);
    rd_data = 8'd0;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; first_addr = '0; last_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {27'd0, busy, done, rd_en, out_valid, out_last}, 32'd0);
    chk("reset_addr_data", {14'd0, rd_addr, out_addr, out_data}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: basic three-word dump, latency checked
    mem[20] = 8'h0F; mem[21] = 8'h55; mem[22] = 8'h05;
    start_dump(5'd20, 5'd22);
    wait_done(3, 1'b1);

    // 2: single word
    mem[30] = 8'h05;
    start_dump(5'd30, 5'd30);
    wait_done(1, 1'b1);

    // 3: window wrapping through the top address
    mem[30] = 8'h05; mem[31] = 8'h00; mem[0] = 8'hA5; mem[1] = 8'hA4;
    start_dump(5'd30, 5'd1);
    wait_done(4, 1'b1);

    // full 32-word window
    start_dump(5'd0, 5'd31);
    wait_done(32, 1'b1);

    // 4: backpressure on the first beat
    out_ready = 1'b0;
    start_dump(5'd4, 5'd6);
    begin
      int w;
      w = 0;
      while (!out_valid && w < 20) begin @(negedge clk); w++; end
      chk("bp_valid_seen", {31'd0, out_valid}, 32'd1);
    end
    repeat (10) @(negedge clk);
    chk("bp_single_read", rd_cnt, 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done(3, 1'b0);

    // 5: start during a dump is ignored
    start_dump(5'd8, 5'd12);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; first_addr = 5'd0; last_addr = 5'd3;
    @(posedge clk); #1 start = 1'b0;
    wait_done(5, 1'b0);

    // 6: reset during the read-wait of the second word
    start_dump(5'd10, 5'd12);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy_wt", {30'd0, busy, out_valid}, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_ctrl", {27'd0, busy, done, rd_en, out_valid, out_last}, 32'd0);
    chk("rst_mid_addr_data", {14'd0, rd_addr, out_addr, out_data}, 32'd0);
    rst = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    chk("rst_no_done", done_cnt, 32'd0);
    start_dump(5'd0, 5'd0);
    wait_done(1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
